// File: rtl/race_ctrl.sv
// ============================================================================
// Module   : race_ctrl
// Brief    : Race flow controller: countdown, lap timing, best lap, finish.
//            Optional pause feature enabled by macro RACE_CTRL_PAUSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module race_ctrl #(
  parameter int NUM_LAPS = 3,
  parameter int COUNT_MS = 1000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        race_start,
  input  logic [5:0]  key,
  input  logic        tick_ms,
  input  logic        checkpoint,
  input  logic        finish_line,
  output logic [1:0]  countdown,
  output logic        player_enable,
  output logic        paused,
  output logic [2:0]  lap,
  output logic [15:0] lap_time_ms,
  output logic [15:0] best_lap_ms,
  output logic        race_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COUNTDOWN = 3'd1;
  localparam logic [2:0] S_RACE      = 3'd2;
  localparam logic [2:0] S_FINISH    = 3'd4;
`ifdef RACE_CTRL_PAUSE_EN
  localparam logic [2:0] S_PAUSE     = 3'd3;
`endif

  localparam logic [2:0]  c_num_laps = 3'(NUM_LAPS);
  localparam logic [15:0] c_sub_last = 16'(COUNT_MS - 1);
  localparam logic [15:0] c_no_lap   = 16'hFFFF;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [15:0] r_sub;
  logic        r_cp_seen;

  logic [1:0]  w_countdown_nxt;
  logic [15:0] w_sub_nxt;
  logic [2:0]  w_lap_nxt;
  logic [15:0] w_lap_time_nxt;
  logic [15:0] w_best_nxt;
  logic        w_done_nxt;
  logic        w_cp_nxt;

  logic        w_fin_ok;
  logic        w_final;
  logic [2:0]  w_lap_inc;
  logic        w_tick_last;

  assign w_fin_ok    = finish_line & r_cp_seen;
  assign w_lap_inc   = lap + 3'd1;
  assign w_final     = (w_lap_inc == c_num_laps);
  assign w_tick_last = tick_ms && (r_sub == c_sub_last);

`ifdef RACE_CTRL_PAUSE_EN
  // A press is a one-hot key that was not already present last cycle.
  logic [5:0] r_key;
  logic       w_key_onehot;
  logic       w_esc_press;
  logic       w_enter_press;

  assign w_key_onehot  = (key != 6'd0) && ((key & (key - 6'd1)) == 6'd0);
  assign w_esc_press   = w_key_onehot && (key != r_key) && (key == 6'b100000);
  assign w_enter_press = w_key_onehot && (key != r_key) && (key == 6'b010000);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_key  <= 6'd0;
      paused <= 1'b0;
    end else begin
      r_key  <= key;
      paused <= (w_state_nxt == S_PAUSE);
    end
  end
`else
  logic w_unused_key;
  assign w_unused_key = ^key;
  assign paused       = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sub         <= 16'd0;
      r_cp_seen     <= 1'b0;
      countdown     <= 2'd0;
      player_enable <= 1'b0;
      lap           <= 3'd0;
      lap_time_ms   <= 16'd0;
      best_lap_ms   <= c_no_lap;
      race_done     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sub         <= w_sub_nxt;
      r_cp_seen     <= w_cp_nxt;
      countdown     <= w_countdown_nxt;
      player_enable <= (w_state_nxt == S_RACE);
      lap           <= w_lap_nxt;
      lap_time_ms   <= w_lap_time_nxt;
      best_lap_ms   <= w_best_nxt;
      race_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (race_start) w_state_nxt = S_COUNTDOWN;
      S_COUNTDOWN: begin
        if (!race_start)                             w_state_nxt = S_IDLE;
        else if (w_tick_last && countdown == 2'd1)   w_state_nxt = S_RACE;
      end
      S_RACE: begin
        if (!race_start)              w_state_nxt = S_IDLE;
        else if (w_fin_ok && w_final) w_state_nxt = S_FINISH;
`ifdef RACE_CTRL_PAUSE_EN
        else if (w_esc_press)         w_state_nxt = S_PAUSE;
`endif
      end
`ifdef RACE_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (!race_start)                        w_state_nxt = S_IDLE;
        else if (w_esc_press || w_enter_press)  w_state_nxt = S_RACE;
      end
`endif
      S_FINISH:    if (!race_start) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_countdown_nxt = countdown;
    w_sub_nxt       = r_sub;
    w_lap_nxt       = lap;
    w_lap_time_nxt  = lap_time_ms;
    w_best_nxt      = best_lap_ms;
    w_done_nxt      = race_done;
    w_cp_nxt        = r_cp_seen;
    case (r_state)
      S_IDLE: begin
        if (race_start) begin
          w_countdown_nxt = 2'd3;
          w_sub_nxt       = 16'd0;
          w_lap_nxt       = 3'd0;
          w_lap_time_nxt  = 16'd0;
          w_best_nxt      = c_no_lap;
          w_done_nxt      = 1'b0;
          w_cp_nxt        = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        if (!race_start) begin
          w_countdown_nxt = 2'd0;
        end else if (w_tick_last) begin
          w_sub_nxt       = 16'd0;
          w_countdown_nxt = countdown - 2'd1;
        end else if (tick_ms) begin
          w_sub_nxt = r_sub + 16'd1;
        end
      end
      S_RACE: begin
        if (race_start) begin
          // Credited lap swallows a coincident tick; final lap keeps its time.
          if (w_fin_ok) begin
            w_lap_nxt  = w_lap_inc;
            w_best_nxt = (lap_time_ms < best_lap_ms) ? lap_time_ms : best_lap_ms;
            w_cp_nxt   = 1'b0;
            if (w_final) w_done_nxt     = 1'b1;
            else         w_lap_time_nxt = 16'd0;
          end else if (tick_ms && lap_time_ms != 16'hFFFF) begin
            w_lap_time_nxt = lap_time_ms + 16'd1;
          end
          if (checkpoint) w_cp_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_race_ctrl.sv
// ============================================================================
// Module   : tb_race_ctrl
// Brief    : Directed self-checking bench for race_ctrl (COUNT_MS=4, NUM_LAPS=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_race_ctrl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        race_start;
  logic [5:0]  key;
  logic        tick_ms;
  logic        checkpoint;
  logic        finish_line;
  logic [1:0]  countdown;
  logic        player_enable;
  logic        paused;
  logic [2:0]  lap;
  logic [15:0] lap_time_ms;
  logic [15:0] best_lap_ms;
  logic        race_done;

  int errors = 0;
  int checks = 0;

  race_ctrl #(.NUM_LAPS(2), .COUNT_MS(4)) dut (
    .pclk(pclk), .rst(rst), .race_start(race_start), .key(key),
    .tick_ms(tick_ms), .checkpoint(checkpoint), .finish_line(finish_line),
    .countdown(countdown), .player_enable(player_enable), .paused(paused),
    .lap(lap), .lap_time_ms(lap_time_ms), .best_lap_ms(best_lap_ms),
    .race_done(race_done)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic tick_n(input int n);
    tick_ms = 1'b1;
    repeat (n) step();
    tick_ms = 1'b0;
  endtask

  task automatic pulse_cp();
    checkpoint = 1'b1; step(); checkpoint = 1'b0;
  endtask

  task automatic pulse_fin();
    finish_line = 1'b1; step(); finish_line = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; race_start = 1'b0; key = 6'd0;
    tick_ms = 1'b0; checkpoint = 1'b0; finish_line = 1'b0;
    step(); step();
    checks++; if (countdown !== 2'd0) begin errors++; $display("FAIL reset_countdown: got %0d expected 0", countdown); end
    checks++; if (player_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %0d expected 0", player_enable); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %0d expected 0", paused); end
    checks++; if (lap !== 3'd0) begin errors++; $display("FAIL reset_lap: got %0d expected 0", lap); end
    checks++; if (lap_time_ms !== 16'd0) begin errors++; $display("FAIL reset_lap_time: got %0d expected 0", lap_time_ms); end
    checks++; if (best_lap_ms !== 16'hFFFF) begin errors++; $display("FAIL reset_best: got %h expected ffff", best_lap_ms); end
    checks++; if (race_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d expected 0", race_done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_countdown();
    race_start = 1'b1;
    step();
    checks++; if (countdown !== 2'd3) begin errors++; $display("FAIL cd_start: got %0d expected 3", countdown); end
    checks++; if (player_enable !== 1'b0) begin errors++; $display("FAIL cd_enable: got %0d expected 0", player_enable); end
    tick_ms = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (countdown !== 2'(3 - k / 4)) begin
        errors++; $display("FAIL cd_tick%0d: got %0d expected %0d", k, countdown, 3 - k / 4);
      end
    end
    tick_ms = 1'b0;
    checks++; if (player_enable !== 1'b1) begin errors++; $display("FAIL cd_race_enable: got %0d expected 1", player_enable); end
    checks++; if (lap_time_ms !== 16'd0) begin errors++; $display("FAIL cd_lap_time: got %0d expected 0", lap_time_ms); end
  endtask

  task automatic test_lap();
    tick_n(10);
    checks++; if (lap_time_ms !== 16'd10) begin errors++; $display("FAIL lap_t10: got %0d expected 10", lap_time_ms); end
    pulse_cp();
    tick_n(5);
    checks++; if (lap_time_ms !== 16'd15) begin errors++; $display("FAIL lap_t15: got %0d expected 15", lap_time_ms); end
    pulse_fin();
    checks++; if (lap !== 3'd1) begin errors++; $display("FAIL lap_count: got %0d expected 1", lap); end
    checks++; if (best_lap_ms !== 16'd15) begin errors++; $display("FAIL lap_best: got %0d expected 15", best_lap_ms); end
    checks++; if (lap_time_ms !== 16'd0) begin errors++; $display("FAIL lap_clear: got %0d expected 0", lap_time_ms); end
  endtask

  task automatic test_no_checkpoint();
    tick_n(3);
    pulse_fin();
    checks++; if (lap !== 3'd1) begin errors++; $display("FAIL nocp_lap: got %0d expected 1", lap); end
    checks++; if (lap_time_ms !== 16'd3) begin errors++; $display("FAIL nocp_time: got %0d expected 3", lap_time_ms); end
    tick_n(4);
    checks++; if (lap_time_ms !== 16'd7) begin errors++; $display("FAIL nocp_count: got %0d expected 7", lap_time_ms); end
  endtask

  task automatic test_pause();
    key = 6'b100000; step(); key = 6'd0;
`ifdef RACE_CTRL_PAUSE_EN
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_on: got %0d expected 1", paused); end
    checks++; if (player_enable !== 1'b0) begin errors++; $display("FAIL pause_enable: got %0d expected 0", player_enable); end
    tick_n(20);
    checks++; if (lap_time_ms !== 16'd7) begin errors++; $display("FAIL pause_hold: got %0d expected 7", lap_time_ms); end
    step();
    key = 6'b010000; step(); key = 6'd0;
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_off: got %0d expected 0", paused); end
    checks++; if (player_enable !== 1'b1) begin errors++; $display("FAIL resume_enable: got %0d expected 1", player_enable); end
    tick_n(2);
`else
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL esc_paused: got %0d expected 0", paused); end
    checks++; if (player_enable !== 1'b1) begin errors++; $display("FAIL esc_enable: got %0d expected 1", player_enable); end
    tick_n(2);
`endif
    checks++; if (lap_time_ms !== 16'd9) begin errors++; $display("FAIL pause_after: got %0d expected 9", lap_time_ms); end
  endtask

  task automatic test_finish();
    pulse_cp();
    tick_n(3);
    pulse_fin();
    checks++; if (lap !== 3'd2) begin errors++; $display("FAIL fin_lap: got %0d expected 2", lap); end
    checks++; if (best_lap_ms !== 16'd12) begin errors++; $display("FAIL fin_best: got %0d expected 12", best_lap_ms); end
    checks++; if (race_done !== 1'b1) begin errors++; $display("FAIL fin_done: got %0d expected 1", race_done); end
    checks++; if (player_enable !== 1'b0) begin errors++; $display("FAIL fin_enable: got %0d expected 0", player_enable); end
    checks++; if (lap_time_ms !== 16'd12) begin errors++; $display("FAIL fin_time_hold: got %0d expected 12", lap_time_ms); end
    tick_n(3);
    checks++; if (lap_time_ms !== 16'd12) begin errors++; $display("FAIL fin_frozen: got %0d expected 12", lap_time_ms); end
    race_start = 1'b0;
    step();
    race_start = 1'b1;
    step();
    checks++; if (countdown !== 2'd3) begin errors++; $display("FAIL restart_cd: got %0d expected 3", countdown); end
    checks++; if (lap !== 3'd0) begin errors++; $display("FAIL restart_lap: got %0d expected 0", lap); end
    checks++; if (best_lap_ms !== 16'hFFFF) begin errors++; $display("FAIL restart_best: got %h expected ffff", best_lap_ms); end
    checks++; if (race_done !== 1'b0) begin errors++; $display("FAIL restart_done: got %0d expected 0", race_done); end
  endtask

  task automatic test_async_reset();
    tick_n(12);
    pulse_cp();
    tick_n(15);
    pulse_fin();
    tick_n(9);
    checks++; if (lap !== 3'd1) begin errors++; $display("FAIL pre_rst_lap: got %0d expected 1", lap); end
    checks++; if (lap_time_ms !== 16'd9) begin errors++; $display("FAIL pre_rst_time: got %0d expected 9", lap_time_ms); end
    #2 rst = 1'b1;
    #1;
    checks++; if (lap !== 3'd0) begin errors++; $display("FAIL arst_lap: got %0d expected 0", lap); end
    checks++; if (lap_time_ms !== 16'd0) begin errors++; $display("FAIL arst_time: got %0d expected 0", lap_time_ms); end
    checks++; if (best_lap_ms !== 16'hFFFF) begin errors++; $display("FAIL arst_best: got %h expected ffff", best_lap_ms); end
    checks++; if (player_enable !== 1'b0) begin errors++; $display("FAIL arst_enable: got %0d expected 0", player_enable); end
    checks++; if (countdown !== 2'd0) begin errors++; $display("FAIL arst_cd: got %0d expected 0", countdown); end
    race_start = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_abort();
    race_start = 1'b1;
    step();
    tick_n(4);
    checks++; if (countdown !== 2'd2) begin errors++; $display("FAIL abort_pre: got %0d expected 2", countdown); end
    race_start = 1'b0;
    step();
    checks++; if (countdown !== 2'd0) begin errors++; $display("FAIL abort_cd: got %0d expected 0", countdown); end
    tick_n(8);
    checks++; if (countdown !== 2'd0) begin errors++; $display("FAIL abort_idle: got %0d expected 0", countdown); end
    checks++; if (player_enable !== 1'b0) begin errors++; $display("FAIL abort_enable: got %0d expected 0", player_enable); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_lap();
    test_no_checkpoint();
    test_pause();
    test_finish();
    test_async_reset();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/race_ctrl.md
RACE_CTRL -- requirements
Module: race_ctrl

Interface
REQ-001 Parameter NUM_LAPS, default 3: laps to complete the race, range 1..7.
REQ-002 Parameter COUNT_MS, default 1000: tick_ms pulses per countdown step, range 2..65535.
REQ-003 pclk  in  1  system pixel clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 race_start  in  1  level from menu FSM; high while the game screen is active.
REQ-006 key  in  6  one-hot key bus: UP=000001, DOWN=000010, LEFT=000100, RIGHT=001000, ENTER=010000, ESC=100000, none=000000.
REQ-007 tick_ms  in  1  single-cycle 1 kHz strobe.
REQ-008 checkpoint  in  1  single-cycle pulse when the car crosses the mid-track checkpoint.
REQ-009 finish_line  in  1  single-cycle pulse when the car crosses the start/finish line.
REQ-010 countdown  out  2  on-screen countdown digit: 3,2,1; 0 = not counting.
REQ-011 player_enable  out  1  car may accept steering/throttle.
REQ-012 paused  out  1  race paused.
REQ-013 lap  out  3  completed laps.
REQ-014 lap_time_ms  out  16  current lap time in ms.
REQ-015 best_lap_ms  out  16  best completed lap time; 16'hFFFF = none yet.
REQ-016 race_done  out  1  race finished.

Function
REQ-017 States: IDLE, COUNTDOWN, RACE, PAUSE, FINISH; all outputs registered.
REQ-018 Key press event: key is one-hot and differs from key registered on the previous cycle; held keys do not repeat.
REQ-019 IDLE: on race_start=1 -> COUNTDOWN, countdown=3, sub-counter=0, lap=0, lap_time_ms=0, best_lap_ms=16'hFFFF, race_done=0.
REQ-020 COUNTDOWN: each tick_ms increments sub-counter; the tick at value COUNT_MS-1 clears it and decrements countdown; the decrement from 1 enters RACE next cycle with countdown=0, player_enable=1.
REQ-021 RACE: each tick_ms increments lap_time_ms, saturating at 16'hFFFF.
REQ-022 checkpoint in RACE sets an internal cp_seen flag.
REQ-023 finish_line in RACE with cp_seen=1: lap+1, best_lap_ms=min(best_lap_ms, lap_time_ms), lap_time_ms=0, cp_seen=0; a tick_ms in the same cycle is discarded.
REQ-024 finish_line with cp_seen=0 is ignored (no lap credit for reversing over the line).
REQ-025 When the increment makes lap equal NUM_LAPS: -> FINISH, race_done=1, player_enable=0, lap_time_ms holds.
REQ-026 checkpoint and finish_line in the same cycle: the finish_line is evaluated first, then checkpoint sets cp_seen.
REQ-027 FINISH: outputs hold; race_start=0 -> IDLE.
REQ-028 race_start=0 in COUNTDOWN, RACE or PAUSE aborts -> IDLE next cycle, countdown=0, player_enable=0, paused=0; lap and times hold until the next start.
REQ-029 IDLE drives countdown=0, player_enable=0, paused=0.

Reset
REQ-030 rst=1 immediately forces IDLE, countdown=0, player_enable=0, paused=0, lap=0, lap_time_ms=0, best_lap_ms=16'hFFFF, race_done=0, cp_seen=0, sub-counter=0, registered key=0; reset mid-race discards all progress.

Configuration
REQ-031 Macro RACE_CTRL_PAUSE_EN defined: ESC press in RACE -> PAUSE (paused=1, player_enable=0, tick_ms/checkpoint/finish_line ignored); ESC or ENTER press in PAUSE -> RACE (paused=0, player_enable=1); ESC press coinciding with a final-lap finish_line -> FINISH; with a non-final finish_line the lap is credited and PAUSE entered.
REQ-032 Macro undefined: PAUSE state absent, paused tied 0, key ignored.

Verification (bench: COUNT_MS=4, NUM_LAPS=2)
REQ-033 race_start 0->1, continuous tick_ms -> countdown 3,2,1 each lasting 4 ticks, then countdown=0, player_enable=1.
REQ-034 RACE, 10 ticks, checkpoint, 5 ticks, finish_line -> lap=1, best_lap_ms=15, lap_time_ms=0.
REQ-035 RACE, finish_line without checkpoint -> lap unchanged, lap_time_ms keeps counting.
REQ-036 Lap 1=15 ms, lap 2=12 ms -> lap=2, best_lap_ms=12, race_done=1, player_enable=0; race_start=0 -> IDLE.
REQ-037 PAUSE_EN: ESC at lap_time_ms=7, 20 ticks, ENTER -> lap_time_ms still 7, paused 1->0; undefined: ESC has no effect.
REQ-038 rst pulse at lap=1, lap_time_ms=9 -> all outputs at reset values without waiting for a clock edge.
